// File: rtl/piso_serializer.sv
// Parallel-in serial-out word serializer with back-to-back reload in the final bit cycle.
// Optional even-parity trailer bit enabled by defining SISO_PARITY_EN.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] din,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_bit;
  logic             last_bit;
  logic             accept;
`ifdef SISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign first_bit = (LSB_FIRST != 0) ? sreg_q[0] : sreg_q[WIDTH-1];
  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  assign accept    = load_valid && load_ready;

  // state register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
`ifdef SISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
`ifdef SISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) begin
`ifdef SISO_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = accept ? S_SHIFT : S_IDLE;
`endif
        end
      end
`ifdef SISO_PARITY_EN
      S_PARITY: state_d = accept ? S_SHIFT : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // capture on accept, otherwise shift toward the first-out end while in SHIFT
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
`ifdef SISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      sreg_d = din;
      cnt_d  = '0;
`ifdef SISO_PARITY_EN
      parity_d = ^din;
`endif
    end else if (state_q == S_SHIFT) begin
      sreg_d = (LSB_FIRST != 0) ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
      cnt_d  = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: load_ready = 1'b1;
      S_SHIFT: begin
        sout       = first_bit;
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifndef SISO_PARITY_EN
        done       = last_bit;
        load_ready = last_bit;
`endif
      end
`ifdef SISO_PARITY_EN
      S_PARITY: begin
        sout       = parity_q;
        sout_valid = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: load_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: LSB-first and MSB-first instances share stimulus; a bit-queue
// model predicts every output, plus directed tables and a downstream 4-stage chain check.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef SISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam logic [4:0] IDLE = 5'b10000;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] din;
  logic l_ready, l_sout, l_valid, l_busy, l_done;
  logic m_ready, m_sout, m_valid, m_busy, m_done;
  logic [3:0] chain;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .din(din),
    .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid), .busy(l_busy), .done(l_done));

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .din(din),
    .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid), .busy(m_busy), .done(m_done));

  // downstream 4-stage shift register fed by the serial stream
  always_ff @(posedge clk) chain <= {chain[2:0], l_sout};

  typedef struct {
    bit         sel;
    logic       lv;
    logic [7:0] din;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   rem   = 0;
  bit   ql[$];
  bit   qm[$];
  bit   hist[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected {load_ready, sout_valid, sout, busy, done} from the pending-bit queue
  function automatic logic [4:0] model_out(input bit isl);
    logic s;
    s = 1'b0;
    if (rem > 0) s = isl ? ql[0] : qm[0];
    return {(rem <= 1), (rem > 0), s, (rem > 0), (rem == 1)};
  endfunction

  function automatic logic [4:0] mid(input bit b);
    return {1'b0, 1'b1, b, 1'b1, 1'b0};
  endfunction

  function automatic logic [4:0] fin(input bit b);
    return {1'b1, 1'b1, b, 1'b1, 1'b1};
  endfunction

  task automatic add(input bit sel, input logic lv, input logic [7:0] d, input logic [4:0] e);
    vec_t v;
    v.sel = sel; v.lv = lv; v.din = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic lv, input logic [W-1:0] d);
    bit acc;
    load_valid = lv;
    din        = d;
    #1;
    chk("lsb_out", {3'b0, l_ready, l_valid, l_sout, l_busy, l_done}, {3'b0, model_out(1'b1)});
    chk("msb_out", {3'b0, m_ready, m_valid, m_sout, m_busy, m_done}, {3'b0, model_out(1'b0)});
    if (hist.size() == 4) chk("chain4", {7'b0, chain[3]}, {7'b0, hist[0]});
    hist.push_back(l_sout);
    if (hist.size() > 4) void'(hist.pop_front());
    acc = lv && (rem <= 1);
    @(posedge clk);
    if (rem > 0) begin
      void'(ql.pop_front());
      void'(qm.pop_front());
      rem--;
    end
    if (acc) begin
      for (int i = 0; i < W; i++) ql.push_back(d[i]);
      for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
`ifdef SISO_PARITY_EN
      ql.push_back(^d);
      qm.push_back(^d);
`endif
      rem = NB;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_lsb", {3'b0, l_ready, l_valid, l_sout, l_busy, l_done}, {3'b0, IDLE});
    chk("rst_msb", {3'b0, m_ready, m_valid, m_sout, m_busy, m_done}, {3'b0, IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;
    rem = 0;
    ql.delete();
    qm.delete();
    hist.delete();
  endtask

  initial begin
    bit s_a[8];
    bit s_b[8];
    reset      = 1'b1;
    load_valid = 1'b0;
    din        = '0;
    #3;
    chk("por_lsb", {3'b0, l_ready, l_valid, l_sout, l_busy, l_done}, {3'b0, IDLE});
    chk("por_msb", {3'b0, m_ready, m_valid, m_sout, m_busy, m_done}, {3'b0, IDLE});
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef SISO_PARITY_EN
    s_a = '{1, 1, 1, 0, 0, 0, 0, 0};
    s_b = '{1, 1, 0, 0, 0, 0, 0, 0};
    add(0, 1, 8'h07, IDLE);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, mid(s_a[i]));
    add(0, 0, 8'h00, fin(1'b1));
    add(0, 1, 8'h03, IDLE);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, mid(s_b[i]));
    add(0, 0, 8'h00, fin(1'b0));
    add(0, 0, 8'h00, IDLE);
`else
    s_a = '{1, 0, 1, 0, 0, 1, 0, 1};
    add(0, 1, 8'hA5, IDLE);
    for (int i = 0; i < 7; i++) add(0, 0, 8'h00, mid(s_a[i]));
    add(0, 0, 8'h00, fin(s_a[7]));
    add(0, 0, 8'h00, IDLE);
    s_a = '{1, 0, 0, 0, 0, 0, 0, 1};
    s_b = '{0, 0, 0, 0, 1, 1, 1, 1};
    add(1, 1, 8'h81, IDLE);
    for (int i = 0; i < 7; i++) add(1, 0, 8'h00, mid(s_a[i]));
    add(1, 1, 8'h0F, fin(s_a[7]));
    for (int i = 0; i < 7; i++) add(1, 0, 8'h00, mid(s_b[i]));
    add(1, 0, 8'h00, fin(s_b[7]));
    add(1, 0, 8'h00, IDLE);
`endif

    foreach (tbl[k]) begin
      load_valid = tbl[k].lv;
      din        = tbl[k].din;
      if (tbl[k].sel)
        chk("tbl_msb", {3'b0, m_ready, m_valid, m_sout, m_busy, m_done}, {3'b0, tbl[k].exp});
      else
        chk("tbl_lsb", {3'b0, l_ready, l_valid, l_sout, l_busy, l_done}, {3'b0, tbl[k].exp});
      cyc(tbl[k].lv, tbl[k].din);
    end

    // load_valid held while busy with din changing mid-word
    cyc(1'b1, 8'h3C);
    for (int k = 0; k < NB; k++) cyc(1'b1, (k < 4) ? 8'hFF : 8'h66);
    for (int k = 0; k < NB + 2; k++) cyc(1'b0, 8'h00);

    // reset in the middle of 8'h3C, then a clean word
    cyc(1'b1, 8'h3C);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00);
    do_reset();
    cyc(1'b1, 8'hC3);
    for (int k = 0; k < NB + 2; k++) cyc(1'b0, 8'h00);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, W'($urandom));
    end
    for (int k = 0; k < NB + 2; k++) cyc(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per word (legal range 2..32).
REQ-002 Parameter LSB_FIRST, default 1; 1 = bit 0 shifted first, 0 = bit WIDTH-1 shifted first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_valid  input  1  upstream offers a word on din.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 load_ready  output  1  block accepts din this cycle.
REQ-008 sout  output  1  serial bit stream, intended to drive the D input of the downstream shift-register stage.
REQ-009 sout_valid  output  1  sout carries a meaningful bit this cycle.
REQ-010 busy  output  1  serialization in progress.
REQ-011 done  output  1  one-cycle pulse coinciding with the final serial bit of a word.

Function
REQ-012 States: IDLE, SHIFT, and PARITY (PARITY only when PARITY_EN is defined); state is registered.
REQ-013 Accept occurs on a rising edge where load_valid=1 and load_ready=1; din is captured into an internal WIDTH-bit shift register and the bit counter is cleared.
REQ-014 load_ready is 1 in IDLE and in the final serial cycle of a word; 0 otherwise.
REQ-015 IDLE -> SHIFT on accept; otherwise remain IDLE with sout=0, sout_valid=0, busy=0.
REQ-016 In SHIFT, sout_valid=1, busy=1, and sout equals the current first-out bit of the shift register (LSB_FIRST selects end); the register shifts one position per cycle and the counter increments.
REQ-017 Latency: the first bit of an accepted word appears on sout in the cycle immediately after the accept edge; a word occupies exactly WIDTH consecutive sout_valid cycles (WIDTH+1 with PARITY_EN).
REQ-018 Final SHIFT cycle (counter = WIDTH-1): without PARITY_EN, done=1; transition to PARITY if PARITY_EN, else to SHIFT on accept or IDLE without accept.
REQ-019 Accept during the final serial cycle reloads the register so the next word's first bit follows with zero gap cycles.
REQ-020 load_valid while load_ready=0 is ignored; din is not sampled and no state changes.
REQ-021 din changes after accept have no effect on the word in flight.
REQ-022 Counter width is ceil(log2(WIDTH)) bits; counter never exceeds WIDTH-1 and is cleared on every accept.
REQ-023 busy = 1 in SHIFT and PARITY, 0 in IDLE.

Reset
REQ-024 Assertion of reset forces, asynchronously, state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, busy=0, done=0; load_ready=1 after reset.
REQ-025 Reset asserted mid-word aborts the word; no done pulse is produced and no remaining bits are emitted after release.
REQ-026 First accept is possible on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro SISO_PARITY_EN: when defined, after the last data bit the block spends one PARITY cycle driving sout = XOR of all WIDTH captured bits (even parity), sout_valid=1, busy=1, done=1, load_ready=1; then SHIFT on accept or IDLE.
REQ-028 When SISO_PARITY_EN is not defined, the PARITY state, parity register and logic are absent, and done/load_ready are asserted in the last data-bit cycle.

Verification
REQ-029 WIDTH=8, LSB_FIRST=1, no parity: accept din=8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 over 8 cycles, sout_valid high 8 cycles, done on cycle 8, then IDLE.
REQ-030 LSB_FIRST=0: accept 8'h81 -> sout 1,0,0,0,0,0,0,1; accept 8'h0F immediately after -> 0,0,0,0,1,1,1,1 with no gap cycle.
REQ-031 SISO_PARITY_EN defined: accept 8'h07 -> 8 data bits then parity bit 1 (three ones), done on 9th cycle; accept 8'h03 -> parity bit 0.
REQ-032 load_valid held high with din=8'hFF while busy and load_ready=0, changing din mid-word -> in-flight word unchanged, new word accepted only in final cycle.
REQ-033 Reset pulsed at bit 4 of 8'h3C -> all outputs 0 immediately, no done, load_ready=1; next accept of 8'hC3 serializes correctly.
REQ-034 Chain sout into the 4-stage shift register downstream: its output reproduces the sout stream delayed by exactly 4 cycles.
